// File: rtl/divider_code_gen.sv
// Sequential ratio encoder: converts num/den (num < den) into the scaler's
// fractional code by restoring long division, one code bit per clock.
module divider_code_gen #(
   parameter int FRAC_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] num,
   input  logic [31:0] den,
   output logic        busy,
   output logic        done,
   output logic [31:0] code,
   output logic        sat
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SAT
   } state_t;

   localparam logic [4:0]  LAST_ITER = 5'(FRAC_BITS - 1);
   localparam logic [31:0] SAT_CODE  = 32'((64'd1 << FRAC_BITS) - 64'd1);

   state_t      state, state_next;
   logic [32:0] rem;
   logic [31:0] den_q;
   logic [31:0] acc;
   logic [4:0]  cnt;

   logic [32:0] t;
   logic        ge;
   logic        last;
   logic [31:0] acc_next;
   logic        busy_next;
   logic        done_next;

   // One restoring-division step: doubled remainder against the held divisor.
   always_comb begin
      t        = rem << 1;
      ge       = (t >= {1'b0, den_q});
      last     = (cnt == LAST_ITER);
      acc_next = acc | (ge ? (32'd1 << cnt) : 32'd0);
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (den != 32'd0 && num < den) state_next = CALC;
               else                           state_next = SAT;
            end
         end
         CALC: begin
            if (last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         SAT: begin
            state_next = IDLE;
            done_next  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem   <= '0;
         den_q <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         code  <= '0;
         sat   <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= done_next;
         case (state)
            IDLE: begin
               if (start) begin
                  rem   <= {1'b0, num};
                  den_q <= den;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               rem <= ge ? (t - {1'b0, den_q}) : t;
               acc <= acc_next;
               cnt <= cnt + 5'd1;
               // code is published only once, when the last bit is known
               if (last) begin
                  code <= acc_next;
                  sat  <= 1'b0;
               end
            end
            SAT: begin
               code <= SAT_CODE;
               sat  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_code_gen.sv
// Directed and random checks of divider_code_gen against a floor(num*2^F/den)
// reference with bit-reversed packing, via an expected-result queue.
module tb_divider_code_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start31;
   logic [31:0] num, den, num31, den31;
   logic        busy, done, sat, busy31, done31, sat31;
   logic [31:0] code, code31;

   always #5 clk = ~clk;

   divider_code_gen #(.FRAC_BITS(10)) dut (
      .clk(clk), .rst(rst), .start(start), .num(num), .den(den),
      .busy(busy), .done(done), .code(code), .sat(sat)
   );

   divider_code_gen #(.FRAC_BITS(31)) dut31 (
      .clk(clk), .rst(rst), .start(start31), .num(num31), .den(den31),
      .busy(busy31), .done(done31), .code(code31), .sat(sat31)
   );

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      logic [31:0] code;
      logic        sat;
      int          lat;
   } exp_t;

   exp_t sb10[$];
   exp_t sb31[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: q = floor(num*2^fb/den); code bit i carries q's bit fb-1-i.
   function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input int fb);
      exp_t        e;
      logic [63:0] q;
      e.num = n;
      e.den = d;
      e.code = '0;
      if (d == 32'd0 || n >= d) begin
         e.code = 32'((64'd1 << fb) - 64'd1);
         e.sat  = 1'b1;
         e.lat  = 2;
      end else begin
         q = (64'(n) << fb) / 64'(d);
         for (int i = 0; i < fb; i++) e.code[i] = q[fb-1-i];
         e.sat = 1'b0;
         e.lat = fb + 1;
      end
      return e;
   endfunction

   function automatic logic [63:0] unpack_code(input logic [31:0] c, input int fb);
      logic [63:0] q = '0;
      for (int i = 0; i < fb; i++) q[fb-1-i] = c[i];
      return q;
   endfunction

   function automatic logic inv_ok(input logic [31:0] c, input logic [31:0] n,
                                   input logic [31:0] d, input int fb);
      logic [63:0] q = unpack_code(c, fb);
      logic [63:0] lhs = 64'(n) << fb;
      return (q * 64'(d) <= lhs) && (lhs < (q + 64'd1) * 64'(d));
   endfunction

   task automatic kick(input logic [31:0] n, input logic [31:0] d);
      num   = n;
      den   = d;
      start = 1'b1;
      sb10.push_back(model(n, d, 10));
      @(posedge clk); #1;
      start = 1'b0;
      num   = $urandom;
      den   = $urandom;
   endtask

   // cyc0 = clocks already elapsed since start was raised (1 right after kick)
   task automatic wait_done(input string tag, input int cyc0);
      int   cyc = cyc0;
      exp_t e;
      while (!done && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) check({tag, " done timeout"}, 64'(done), 64'd1);
      if (sb10.size() == 0) begin
         check({tag, " queue empty"}, 64'(sb10.size()), 64'd1);
      end else begin
         e = sb10.pop_front();
         if (done) begin
            check({tag, " latency"}, 64'(cyc), 64'(e.lat));
            check({tag, " code"}, 64'(code), 64'(e.code));
            check({tag, " sat"}, 64'(sat), 64'(e.sat));
            if (!e.sat) check({tag, " floor"}, 64'(inv_ok(code, e.num, e.den, 10)), 64'd1);
         end
      end
   endtask

   task automatic run31(input logic [31:0] n, input logic [31:0] d);
      int   cyc = 1;
      exp_t e;
      num31   = n;
      den31   = d;
      start31 = 1'b1;
      sb31.push_back(model(n, d, 31));
      @(posedge clk); #1;
      start31 = 1'b0;
      while (!done31 && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sb31.pop_front();
      if (!done31) check("f31 done timeout", 64'(done31), 64'd1);
      else begin
         check("f31 latency", 64'(cyc), 64'(e.lat));
         check("f31 code", 64'(code31), 64'(e.code));
         check("f31 floor", 64'(inv_ok(code31, n, d, 31)), 64'd1);
      end
   endtask

   initial begin
      int          seen;
      int          scaled;
      logic [31:0] rn, rd;

      rst = 1'b1; start = 1'b0; start31 = 1'b0;
      num = '0; den = '0; num31 = '0; den31 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset code", 64'(code), 64'd0);
      check("reset sat", 64'(sat), 64'd0);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("idle no done", 64'(seen), 64'd0);

      kick(32'd1, 32'd3);
      check("busy after start", 64'(busy), 64'd1);
      wait_done("1/3", 1);
      scaled = 0;
      for (int k = 1; k <= 10; k++) if (code[k-1]) scaled += 1024 >> k;
      check("scaler 1024*1/3", 64'(scaled), 64'd341);
      @(posedge clk); #1;
      check("done one cycle", 64'(done), 64'd0);
      check("idle busy", 64'(busy), 64'd0);

      kick(32'd3, 32'd4);                  wait_done("3/4", 1);
      kick(32'd1, 32'd2);                  wait_done("1/2", 1);
      kick(32'hFFFF_FFFE, 32'hFFFF_FFFF);  wait_done("max ratio", 1);
      kick(32'd0, 32'd7);                  wait_done("zero num", 1);
      kick(32'd5, 32'd0);                  wait_done("den zero", 1);
      check("sat code held", 64'(code), 64'h3FF);
      kick(32'd9, 32'd9);                  wait_done("num eq den", 1);
      kick(32'd1, 32'd4);                  wait_done("1/4 after sat", 1);

      // second start while busy must be ignored
      kick(32'd1, 32'd3);
      repeat (2) begin @(posedge clk); #1; end
      num = 32'd1; den = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("ignore busy start", 4);
      // start accepted in the done cycle
      kick(32'd1, 32'd2);
      wait_done("back to back", 1);

      // reset during CALC aborts
      kick(32'd1, 32'd3);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb10.delete();
      check("abort busy", 64'(busy), 64'd0);
      check("abort code", 64'(code), 64'd0);
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("abort no done", 64'(seen), 64'd0);
      kick(32'd3, 32'd4);
      wait_done("after abort", 1);

      for (int i = 0; i < 1500; i++) begin
         rd = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 2000));
         if (rd == 32'd0) rd = 32'd1;
         rn = $urandom % rd;
         kick(rn, rd);
         wait_done("rand", 1);
      end

      run31(32'd1, 32'd3);
      run31(32'hFFFF_FFFE, 32'hFFFF_FFFF);
      for (int i = 0; i < 150; i++) begin
         rd = $urandom;
         if (rd == 32'd0) rd = 32'd1;
         rn = $urandom % rd;
         run31(rn, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
